// File: rtl/uart_word_tx.sv
// UART transmitter that sends 1 to 4 bytes of a 32-bit word, least significant byte first,
// as 8N1 frames with no idle gap between bytes.
module uart_word_tx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] word_in,
  input  logic [1:0]  num_bytes,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

  state_t      state, state_next;
  logic [15:0] baud_cnt, baud_next;
  logic [2:0]  bit_cnt, bit_next;
  logic [1:0]  byte_idx, byte_next;
  logic [31:0] word_reg, word_next;
  logic [1:0]  nbytes_reg, nbytes_next;
  logic        tx_next;
  logic        baud_last;
  logic [7:0]  cur_byte;

  assign baud_last  = (baud_cnt == BAUD_MAX);
  assign word_ready = (state == IDLE);
  assign busy       = ~word_ready;
  assign done       = (state == STOP) && baud_last && (byte_idx == nbytes_reg);

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    baud_next   = baud_cnt;
    bit_next    = bit_cnt;
    byte_next   = byte_idx;
    word_next   = word_reg;
    nbytes_next = nbytes_reg;

    unique case (state)
      IDLE: begin
        if (word_valid) begin
          state_next  = START;
          word_next   = word_in;
          nbytes_next = num_bytes;
          byte_next   = 2'd0;
          bit_next    = 3'd0;
          baud_next   = 16'd0;
        end
      end
      START: begin
        if (baud_last) begin
          baud_next  = 16'd0;
          bit_next   = 3'd0;
          state_next = DATA;
        end else begin
          baud_next = baud_cnt + 16'd1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_next = 16'd0;
          if (bit_cnt == 3'd7) state_next = STOP;
          else                 bit_next   = bit_cnt + 3'd1;
        end else begin
          baud_next = baud_cnt + 16'd1;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_next = 16'd0;
          if (byte_idx == nbytes_reg) begin
            state_next = IDLE;
          end else begin
            byte_next  = byte_idx + 2'd1;
            state_next = START;
          end
        end else begin
          baud_next = baud_cnt + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    // tx is computed from the upcoming state so the registered line lines up with it.
    cur_byte = word_next[{byte_next, 3'b000} +: 8];
    unique case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = cur_byte[bit_next];
      default: tx_next = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: the latched word registers are ordinary flops and are reset along with
  // the control state, so no stale data survives a reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt   <= 16'd0;
      bit_cnt    <= 3'd0;
      byte_idx   <= 2'd0;
      word_reg   <= 32'd0;
      nbytes_reg <= 2'd0;
      tx         <= 1'b1;
    end else begin
      baud_cnt   <= baud_next;
      bit_cnt    <= bit_next;
      byte_idx   <= byte_next;
      word_reg   <= word_next;
      nbytes_reg <= nbytes_next;
      tx         <= tx_next;
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx at 4 clocks per bit; outputs sampled on the falling edge.
module tb_uart_word_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] word_in;
  logic [1:0]  num_bytes;
  logic        word_valid;
  logic        word_ready;
  logic        tx;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  uart_word_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .word_in    (word_in),
    .num_bytes  (num_bytes),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .tx         (tx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tx"}, tx, 1);
    check({tag, "_ready"}, word_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // Present a word at the falling edge and hold valid across exactly one rising edge.
  task automatic accept(input logic [31:0] w, input logic [1:0] n);
    @(negedge clk);
    word_in    = w;
    num_bytes  = n;
    word_valid = 1'b1;
    @(posedge clk);
    #1 word_valid = 1'b0;
  endtask

  // Check the first nbits bit periods of one frame; optionally pulse a rival request mid-frame.
  task automatic check_byte(input logic [7:0] b, input bit last, input int nbits, input bit inject);
    logic exp_tx;
    for (int k = 0; k < nbits; k++) begin
      if (k == 0)      exp_tx = 1'b0;
      else if (k == 9) exp_tx = 1'b1;
      else             exp_tx = b[k-1];
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        check("tx", tx, exp_tx);
        check("done", done, (last && k == 9 && c == CPB - 1) ? 1 : 0);
        check("busy", busy, 1);
        if (inject && k == 3 && c == 0) begin
          word_in    = 32'hFFFF_FFFF;
          num_bytes  = 2'd3;
          word_valid = 1'b1;
        end
        if (inject && k == 3 && c == 1) word_valid = 1'b0;
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    word_in    = 32'd0;
    num_bytes  = 2'd0;
    word_valid = 1'b0;
    #1 check_idle("async_reset");
    repeat (2) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;
    @(negedge clk);
    check_idle("after_reset");

    // Four-byte word, least significant byte first.
    accept(32'h4433_2211, 2'd3);
    check_byte(8'h11, 0, 10, 0);
    check_byte(8'h22, 0, 10, 0);
    check_byte(8'h33, 0, 10, 0);
    check_byte(8'h44, 1, 10, 0);
    @(negedge clk);
    check_idle("word4_end");

    // Single byte.
    repeat (3) @(negedge clk);
    accept(32'hA5A5_A5C3, 2'd0);
    check_byte(8'hC3, 1, 10, 0);
    @(negedge clk);
    check_idle("word1_end");

    // A request arriving while busy must not disturb the word in flight.
    accept(32'h0000_0000, 2'd1);
    check_byte(8'h00, 0, 10, 1);
    check_byte(8'h00, 1, 10, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_idle("ignored_word");
    end

    // Asynchronous reset during data bits of byte 1.
    accept(32'h4433_2211, 2'd3);
    check_byte(8'h11, 0, 10, 0);
    check_byte(8'h22, 0, 4, 0);
    #2 reset = 1'b1;
    #1 check_idle("midframe_reset");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_idle("post_abort");
    end

    // Valid held high: one idle-high cycle between back-to-back words.
    @(negedge clk);
    word_in    = 32'h0000_00AB;
    num_bytes  = 2'd0;
    word_valid = 1'b1;
    @(posedge clk);
    #1 word_in = 32'h0000_00CD;
    check_byte(8'hAB, 1, 10, 0);
    @(negedge clk);
    check("gap_tx", tx, 1);
    check("gap_ready", word_ready, 1);
    @(posedge clk);
    #1 word_valid = 1'b0;
    check_byte(8'hCD, 1, 10, 0);
    @(negedge clk);
    check_idle("b2b_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_word_tx.md
UART_WORD_TX -- requirements
Module: uart_word_tx

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 434, meaning clock cycles per UART bit (legal range 2 to 65535).
REQ-002 The module SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 The module SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 The module SHALL have port word_in  input  32  word to transmit, sampled only on acceptance.
REQ-005 The module SHALL have port num_bytes  input  2  number of bytes to send minus one, sampled only on acceptance.
REQ-006 The module SHALL have port word_valid  input  1  request to transmit word_in.
REQ-007 The module SHALL have port word_ready  output  1  high when the module can accept a word.
REQ-008 The module SHALL have port tx  output  1  serial line, idle high.
REQ-009 The module SHALL have port busy  output  1  high while any frame is in progress.
REQ-010 The module SHALL have port done  output  1  one-cycle pulse at end of the last stop bit.

Function
REQ-011 The module SHALL use an FSM with states IDLE, START, DATA and STOP.
REQ-012 The module SHALL drive word_ready high exactly when the state is IDLE, and busy as the inverse of word_ready.
REQ-013 Acceptance SHALL occur on a rising edge with word_valid and word_ready both high; the module SHALL then latch word_in and num_bytes, clear the byte index to 0 and enter START.
REQ-014 The module SHALL ignore word_valid while not in IDLE, leaving latched data unchanged.
REQ-015 Byte order SHALL be index 0 = word[7:0], 1 = word[15:8], 2 = word[23:16], 3 = word[31:24], using a 2-bit byte index.
REQ-016 START SHALL hold tx low for CLKS_PER_BIT cycles, beginning the cycle after acceptance.
REQ-017 DATA SHALL send the 8 bits of the current byte LSB first, each held for CLKS_PER_BIT cycles, using a 3-bit bit counter.
REQ-018 STOP SHALL hold tx high for CLKS_PER_BIT cycles; there SHALL be no parity bit.
REQ-019 At the end of STOP, if the byte index is below the latched num_bytes, the module SHALL increment the index and enter START on the next cycle with no idle gap.
REQ-020 At the end of STOP, if the byte index equals the latched num_bytes, the module SHALL pulse done high for that final STOP cycle and enter IDLE.
REQ-021 Each byte SHALL occupy exactly 10*CLKS_PER_BIT cycles, so a word takes (num_bytes+1)*10*CLKS_PER_BIT cycles from the first start-bit cycle.
REQ-022 The baud counter SHALL be 16 bits wide, count 0 to CLKS_PER_BIT-1, and wrap to 0 at every bit boundary.
REQ-023 tx SHALL be driven from a register, with no combinational path from any input.
REQ-024 A new word presented with word_valid held high SHALL be accepted in the first IDLE cycle after done, giving exactly one idle-high tx cycle between words.

Reset
REQ-025 While reset is high, the module SHALL immediately, without waiting for clk, set state IDLE, tx 1, done 0, busy 0, word_ready 1, and clear all counters and the byte index.
REQ-026 Reset asserted mid-frame SHALL abort the frame; after release the module SHALL start no transmission until a new acceptance.
REQ-027 Latched word and num_bytes registers SHALL reset to 0.

Verification (CLKS_PER_BIT=4)
REQ-028 word_in=0x44332211, num_bytes=3, one-cycle valid -> tx shows bytes 0x11,0x22,0x33,0x44 LSB first with start/stop framing, 160 cycles, done pulses once in cycle 160, word_ready returns high the next cycle.
REQ-029 word_in=0xA5A5A5C3, num_bytes=0 -> single frame 0,1,1,0,0,0,0,1,1,1 at 4 cycles per bit, 40 cycles, done pulse once.
REQ-030 Valid pulsed with word_in=0xFFFFFFFF while busy sending a 0x00000000 word -> second word ignored, tx carries only 0x00 bytes.
REQ-031 Reset asserted during DATA of byte 1 of 0x44332211 -> tx=1 and word_ready=1 with no clock edge, no done pulse, tx stays high after release.
REQ-032 word_valid held high with two queued words 0x000000AB then 0x000000CD, num_bytes=0 -> frames back to back, exactly one idle-high cycle between the first stop bit and the second start bit.
